// File: rtl/ook_pkg.sv
// ook_pkg: shared OOK link constants and receiver FSM states.
// Build option OOK_RX_PARITY_EN adds an even-parity symbol after bit 7.
package ook_pkg;
    localparam int CARRIER_DIV = 24;
    localparam int HOLD_CYCLES = 48;
    localparam int BIT_CYCLES  = 1000;
`ifdef OOK_RX_PARITY_EN
    localparam int DATA_SYMS = 9;
`else
    localparam int DATA_SYMS = 8;
`endif
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_t;
endpackage

// File: rtl/ook_carrier_det.sv
// ook_carrier_det: synchronizes rf_in and turns carrier edges into an envelope.
module ook_carrier_det #(
    parameter int HOLD_CYCLES = 48
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rf_in,
    output logic env
);
    localparam int GW = $clog2(HOLD_CYCLES + 1);
    localparam logic [GW-1:0] HOLD = GW'(HOLD_CYCLES);
    // sync[1:0] is the synchronizer, sync[2] the previous synchronized sample
    logic [2:0] sync;
    logic [GW-1:0] gap;
    logic rise;
    assign rise = sync[1] & ~sync[2];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sync <= '0;
            gap  <= HOLD;
            env  <= 1'b0;
        end else begin
            sync <= {sync[1:0], rf_in};
            gap  <= rise ? '0 : (gap == HOLD ? gap : gap + 1'b1);
            env  <= rise ? (env | (gap < HOLD)) : (env & (gap < HOLD - 1'b1));
        end
endmodule

// File: rtl/ook_rx.sv
// ook_rx: OOK byte receiver; envelope detector plus mid-bit sampling FSM.
// Build option OOK_RX_PARITY_EN enables an even-parity check before the stop bit.
module ook_rx import ook_pkg::*; #(
    parameter int CARRIER_DIV = ook_pkg::CARRIER_DIV,
    parameter int HOLD_CYCLES = ook_pkg::HOLD_CYCLES,
    parameter int BIT_CYCLES  = ook_pkg::BIT_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rf_in,
    output logic       env_out,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int TW = $clog2(BIT_CYCLES);
    localparam logic [TW-1:0] FULL = TW'(BIT_CYCLES - 1);
    localparam logic [TW-1:0] HALF = TW'(BIT_CYCLES / 2 - 1);

    if (HOLD_CYCLES <= CARRIER_DIV) begin : g_hold_chk
        $error("HOLD_CYCLES must exceed CARRIER_DIV");
    end

    rx_state_t state, nxt;
    logic [TW-1:0] tmr, tmr_n;
    logic [3:0] cnt, cnt_n;
    logic [DATA_SYMS-1:0] sr, sr_n;
    logic env_d, tick, good, dv_n, fe_n;

    ook_carrier_det #(.HOLD_CYCLES(HOLD_CYCLES)) u_det (
        .clk   (clk),
        .rst_n (rst_n),
        .rf_in (rf_in),
        .env   (env_out)
    );

    assign tick = tmr == '0;
    assign busy = state != IDLE;
`ifdef OOK_RX_PARITY_EN
    assign good = ~^sr;
`else
    assign good = 1'b1;
`endif

    always_comb begin
        nxt   = state;
        tmr_n = tick ? tmr : tmr - 1'b1;
        cnt_n = cnt;
        sr_n  = sr;
        dv_n  = 1'b0;
        fe_n  = 1'b0;
        case (state)
            IDLE: if (env_out & ~env_d) begin
                nxt   = START;
                tmr_n = HALF;
            end
            START: if (tick) begin
                nxt   = env_out ? DATA : IDLE;
                tmr_n = FULL;
                cnt_n = '0;
            end
            DATA: if (tick) begin
                sr_n  = {env_out, sr[DATA_SYMS-1:1]};
                cnt_n = cnt + 1'b1;
                tmr_n = FULL;
                nxt   = cnt == 4'(DATA_SYMS - 1) ? STOP : DATA;
            end
            STOP: if (tick) begin
                nxt  = env_out ? WAIT_IDLE : IDLE;
                dv_n = ~env_out & good;
                fe_n = env_out | ~good;
            end
            WAIT_IDLE: if (!env_out) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            tmr        <= '0;
            cnt        <= '0;
            sr         <= '0;
            env_d      <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= nxt;
            tmr        <= tmr_n;
            cnt        <= cnt_n;
            sr         <= sr_n;
            env_d      <= env_out;
            data_out   <= dv_n ? sr[7:0] : data_out;
            data_valid <= dv_n;
            frame_err  <= fe_n;
        end
endmodule

// File: tb/tb_ook_rx.sv
// tb_ook_rx: directed frames against a frame-level model of expected bytes/errors.
module tb_ook_rx;
    localparam int BIT = 1000;
    localparam int DIV = 24;

    logic clk = 1'b0, rst_n = 1'b0, rf_in = 1'b0;
    logic env_out, data_valid, frame_err, busy;
    logic [7:0] data_out;
    logic key = 1'b0, pulse = 1'b0;
    int total = 0, bad = 0, dv_cnt = 0, fe_cnt = 0;
    int q_kind[$];
    logic [7:0] q_byte[$];
    logic [7:0] exp_dout = 8'h00;
    bit e1, b1, e2, b2;

    ook_rx #(.CARRIER_DIV(DIV), .HOLD_CYCLES(48), .BIT_CYCLES(BIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rf_in      (rf_in),
        .env_out    (env_out),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    initial begin : carrier
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #2;
            ph = (ph + 1) % DIV;
            rf_in = (key && ph < DIV / 2) || pulse;
        end
    end

    // frame-level model: each completed frame yields one queued outcome (0 = byte, 1 = error)
    initial begin : compare
        int k;
        forever begin
            @(negedge clk);
            if (!rst_n) exp_dout = 8'h00;
            else begin
                check("pulse exclusive", {31'd0, data_valid & frame_err}, 0);
                k = q_kind.size() > 0 ? q_kind[0] : -1;
                if (data_valid) begin
                    dv_cnt++;
                    check("data_valid expected", k, 0);
                    if (k == 0) begin
                        check("data_out byte", data_out, q_byte[0]);
                        exp_dout = q_byte[0];
                        void'(q_kind.pop_front());
                        void'(q_byte.pop_front());
                    end
                end
                if (frame_err) begin
                    fe_cnt++;
                    check("frame_err expected", k, 1);
                    if (k == 1) begin
                        void'(q_kind.pop_front());
                        void'(q_byte.pop_front());
                    end
                end
                check("data_out hold", data_out, exp_dout);
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit stop_on, input bit par_bad);
        bit sym[$];
        sym.push_back(1'b1);
        for (int i = 0; i < 8; i++) sym.push_back(b[i]);
`ifdef OOK_RX_PARITY_EN
        sym.push_back((^b) ^ par_bad);
`endif
        sym.push_back(stop_on);
        q_kind.push_back((stop_on || par_bad) ? 1 : 0);
        q_byte.push_back(b);
        foreach (sym[i]) begin
            key = sym[i];
            repeat (BIT) @(posedge clk);
        end
        if (!stop_on) repeat (300) @(posedge clk);
    endtask

    task automatic watch(input int n, output bit e, output bit b);
        e = 1'b0;
        b = 1'b0;
        repeat (n) begin
            @(negedge clk);
            e |= env_out;
            b |= busy;
        end
    endtask

    initial begin : main
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("reset env_out", {31'd0, env_out}, 0);
        check("reset data_out", data_out, 8'h00);
        check("reset data_valid", {31'd0, data_valid}, 0);
        check("reset frame_err", {31'd0, frame_err}, 0);
        check("reset busy", {31'd0, busy}, 0);
        rst_n = 1'b1;
        repeat (100) @(posedge clk);

        send(8'hA5, 1'b0, 1'b0);
        @(negedge clk);
        check("A5 data_out", data_out, 8'hA5);
        check("A5 valid count", dv_cnt, 1);
        check("A5 err count", fe_cnt, 0);
        check("A5 busy idle", {31'd0, busy}, 0);

        pulse = 1'b1;
        repeat (12) @(posedge clk);
        pulse = 1'b0;
        watch(400, e1, b1);
        check("pulse env_out", {31'd0, e1}, 0);
        check("pulse busy", {31'd0, b1}, 0);

        key = 1'b1;
        watch(400, e1, b1);
        key = 1'b0;
        watch(1200, e2, b2);
        check("burst env seen", {31'd0, e1}, 1);
        check("burst busy seen", {31'd0, b1 | b2}, 1);
        check("burst busy end", {31'd0, busy}, 0);
        check("burst valid count", dv_cnt, 1);
        check("burst err count", fe_cnt, 0);

        send(8'h3C, 1'b1, 1'b0);
        watch(1500, e1, b1);
        check("3C err count", fe_cnt, 1);
        check("3C data_out kept", data_out, 8'hA5);
        check("3C busy held", {31'd0, busy}, 1);
        key = 1'b0;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("3C busy release", {31'd0, busy}, 0);
        repeat (300) @(posedge clk);

        key = 1'b1;
        repeat (5500) @(posedge clk);
        #3;
        rst_n = 1'b0;
        key = 1'b0;
        #1;
        check("midreset env_out", {31'd0, env_out}, 0);
        check("midreset data_out", data_out, 8'h00);
        check("midreset data_valid", {31'd0, data_valid}, 0);
        check("midreset frame_err", {31'd0, frame_err}, 0);
        check("midreset busy", {31'd0, busy}, 0);
        repeat (10) @(posedge clk);
        rst_n = 1'b1;
        repeat (300) @(posedge clk);
        check("midreset valid count", dv_cnt, 1);
        check("midreset err count", fe_cnt, 1);

        send(8'h12, 1'b0, 1'b0);
        @(negedge clk);
        check("12 data_out", data_out, 8'h12);
        check("12 valid count", dv_cnt, 2);

`ifdef OOK_RX_PARITY_EN
        send(8'h07, 1'b0, 1'b1);
        @(negedge clk);
        check("07 bad parity err", fe_cnt, 2);
        check("07 bad parity data_out", data_out, 8'h12);
        send(8'h07, 1'b0, 1'b0);
        @(negedge clk);
        check("07 good parity data_out", data_out, 8'h07);
        check("07 good parity valid", dv_cnt, 3);
`endif

        check("outcomes pending", q_kind.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ook_rx.md
OOK_RX -- requirements
Module: ook_rx

Interface
REQ-001 Parameter CARRIER_DIV, default 24: nominal clk cycles per carrier period (250 kHz at 6 MHz).
REQ-002 Parameter HOLD_CYCLES, default 48: maximum rising-edge gap, in clk cycles, that still counts as carrier present.
REQ-003 Parameter BIT_CYCLES, default 1000: clk cycles per keyed symbol.
REQ-004 Port clk, input, 1: sole clock, 6 MHz from the on-chip HFOSC.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port rf_in, input, 1: raw keyed carrier from the pin; asynchronous to clk.
REQ-007 Port env_out, output, 1: demodulated envelope; 1 = carrier present.
REQ-008 Port data_out, output, 8: last received byte.
REQ-009 Port data_valid, output, 1: one-cycle pulse when data_out updates.
REQ-010 Port frame_err, output, 1: one-cycle pulse on a framing error (or a parity error when enabled).
REQ-011 Port busy, output, 1: high whenever the decoder FSM is not in IDLE.

Function
REQ-012 rf_in SHALL pass through a 2-flop synchronizer; rising edges SHALL be detected on the synchronized signal.
REQ-013 The gap counter SHALL clear on each rising edge, increment otherwise, and saturate at HOLD_CYCLES.
REQ-014 env_out SHALL rise the cycle after a rising edge that arrives while the gap counter is below HOLD_CYCLES, so at least two edges spaced within HOLD_CYCLES are required.
REQ-015 env_out SHALL fall the cycle the gap counter reaches HOLD_CYCLES.
REQ-016 A single isolated edge SHALL never assert env_out.
REQ-017 Line coding: idle = envelope 0; start bit = 1; 8 data bits LSB first (1 = carrier on); stop bit = 0.
REQ-018 The decoder FSM SHALL have exactly the states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-019 IDLE -> START on an env_out 0->1 transition; the bit timer SHALL load BIT_CYCLES/2.
REQ-020 In START, when the timer expires: env_out=1 -> DATA with the timer loaded to BIT_CYCLES; env_out=0 -> IDLE with no output pulse (glitch rejection).
REQ-021 In DATA, env_out SHALL be sampled at each timer expiry into a shift register; after the 8th sample the FSM SHALL go to STOP.
REQ-022 In STOP, at timer expiry: env_out=0 -> data_out updated and data_valid pulsed the following cycle, then IDLE.
REQ-023 In STOP, at timer expiry: env_out=1 -> frame_err pulsed, data_out unchanged, then WAIT_IDLE.
REQ-024 WAIT_IDLE -> IDLE on the first cycle env_out=0.
REQ-025 data_valid and frame_err SHALL never assert in the same cycle.
REQ-026 data_out SHALL hold its value until the next valid byte.
REQ-027 Envelope transitions during DATA or STOP SHALL NOT resynchronize the bit timer.

Reset
REQ-028 rst_n low SHALL immediately clear: synchronizer, gap counter (to HOLD_CYCLES, i.e. no carrier), env_out=0, data_out=0x00, data_valid=0, frame_err=0, busy=0, FSM=IDLE.
REQ-029 Reset asserted mid-frame SHALL discard the partial byte with no pulse on any output.
REQ-030 After rst_n deasserts, a frame SHALL decode only from a fresh env_out rising edge.

Configuration
REQ-031 Macro OOK_RX_PARITY_EN defined: an even-parity bit SHALL follow bit 7 and precede the stop bit.
REQ-032 With OOK_RX_PARITY_EN defined, a parity mismatch with a good stop bit SHALL pulse frame_err instead of data_valid and go to IDLE.
REQ-033 Macro OOK_RX_PARITY_EN undefined: the frame is 10 symbols and no parity logic exists.

Structure
REQ-034 Package ook_pkg SHALL hold the FSM state enum and the default constants CARRIER_DIV=24, HOLD_CYCLES=48 and BIT_CYCLES=1000, shared with the transmitter.
REQ-035 Sub-module ook_carrier_det SHALL contain the synchronizer, edge detector, gap counter and env_out generation.
REQ-036 The bit-timing FSM SHALL reside in ook_rx.

Verification
REQ-037 Byte 0xA5 keyed with a 24-cycle carrier at 1000 cycles per bit -> data_out=0xA5 with one data_valid pulse, frame_err=0.
REQ-038 Single rf_in pulse of 12 cycles -> env_out stays 0, busy stays 0.
REQ-039 Carrier burst of 400 cycles, then idle -> START aborts to IDLE; no data_valid and no frame_err.
REQ-040 Byte 0x3C with the stop bit keyed on -> frame_err pulse, data_out unchanged, busy held until the carrier drops.
REQ-041 rst_n pulsed low during bit 4 of 0xFF -> all outputs reset immediately; the next 0x12 frame decodes correctly.
REQ-042 With OOK_RX_PARITY_EN, 0x07 sent with wrong parity -> frame_err pulse; sent with correct parity -> data_valid with data_out=0x07.
